// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter with bounded burst retention between the host command port (req 0)
// and the fill/blit engine (req 1), feeding the SRAM pending-write queue through a one-entry output register.
module pixel_write_arbiter #(
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     enable,
    input  logic [1:0]               reqValid,
    input  logic [ADDR_W+DATA_W-1:0] reqBus0,
    input  logic [ADDR_W+DATA_W-1:0] reqBus1,
    output logic [1:0]               reqReady,
    output logic [ADDR_W+DATA_W-1:0] pendingWriteQueueWriteBus,
    output logic                     pendingWriteQueueWriteRequest,
    input  logic                     pendingWriteQueueWriteFull,
    output logic                     idle
);

    localparam int unsigned WORD_W = ADDR_W + DATA_W;
    localparam int unsigned CNT_W  = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);

    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grant_e;

    logic              outValid_q, outValid_d;
    logic [WORD_W-1:0] bus_q, bus_d;
    grant_e            lastGrant_q, lastGrant_d;
    logic [CNT_W-1:0]  burstCount_q, burstCount_d;

    logic   writeFire;
    logic   slotFree;
    logic   transfer;
    logic   lastValid;
    grant_e otherGrant;
    grant_e winner;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            outValid_q   <= 1'b0;
            bus_q        <= '0;
            lastGrant_q  <= GRANT_REQ1;
            burstCount_q <= '0;
        end else begin
            outValid_q   <= outValid_d;
            bus_q        <= bus_d;
            lastGrant_q  <= lastGrant_d;
            burstCount_q <= burstCount_d;
        end
    end

    always_comb begin
        writeFire  = outValid_q & ~pendingWriteQueueWriteFull;
        slotFree   = ~outValid_q | writeFire;
        otherGrant = (lastGrant_q == GRANT_REQ0) ? GRANT_REQ1 : GRANT_REQ0;
        lastValid  = (lastGrant_q == GRANT_REQ0) ? reqValid[0] : reqValid[1];

        // burstCount==0 means no streak is open, so contention hands over to the other side;
        // this is what makes req 0 win first out of reset.
        winner = lastGrant_q;
        unique case (reqValid)
            2'b01:   winner = GRANT_REQ0;
            2'b10:   winner = GRANT_REQ1;
            2'b11:   winner = (burstCount_q != '0 && burstCount_q < BURST_MAX) ? lastGrant_q : otherGrant;
            default: winner = lastGrant_q;
        endcase

        transfer = resetN & enable & slotFree & (|reqValid);
        reqReady = '0;
        if (transfer) begin
            reqReady = (winner == GRANT_REQ0) ? 2'b01 : 2'b10;
        end

        outValid_d   = outValid_q;
        bus_d        = bus_q;
        lastGrant_d  = lastGrant_q;
        burstCount_d = burstCount_q;
        if (transfer) begin
            outValid_d  = 1'b1;
            bus_d       = (winner == GRANT_REQ0) ? reqBus0 : reqBus1;
            lastGrant_d = winner;
            if (winner == lastGrant_q) begin
                burstCount_d = (burstCount_q >= BURST_MAX) ? BURST_MAX : burstCount_q + BURST_ONE;
            end else begin
                burstCount_d = BURST_ONE;
            end
        end else begin
            if (writeFire) begin
                outValid_d = 1'b0;
            end
            if (!lastValid) begin
                burstCount_d = '0;
            end
        end
    end

    assign pendingWriteQueueWriteBus     = bus_q;
    assign pendingWriteQueueWriteRequest = writeFire;
    assign idle                          = ~outValid_q & ~(|reqValid);

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: hand-derived vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_pixel_write_arbiter;

    localparam int unsigned AW = 17;
    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;
    localparam int unsigned W  = AW + DW;

    logic         clock = 1'b0;
    logic         resetN;
    logic         enable;
    logic [1:0]   reqValid;
    logic [W-1:0] reqBus0;
    logic [W-1:0] reqBus1;
    logic [1:0]   reqReady;
    logic [W-1:0] qBus;
    logic         qWrite;
    logic         qFull;
    logic         idle;

    pixel_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clock                         (clock),
        .resetN                        (resetN),
        .enable                        (enable),
        .reqValid                      (reqValid),
        .reqBus0                       (reqBus0),
        .reqBus1                       (reqBus1),
        .reqReady                      (reqReady),
        .pendingWriteQueueWriteBus     (qBus),
        .pendingWriteQueueWriteRequest (qWrite),
        .pendingWriteQueueWriteFull    (qFull),
        .idle                          (idle)
    );

    always #5 clock = ~clock;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference model: held entry as a queue, the requester last granted and its streak length.
    logic [W-1:0] held[$];
    int           lastG;
    int           streak;
    int           accepted;
    int           pushed;

    typedef struct {
        logic       en;
        logic [1:0] v;
        logic       full;
        logic [1:0] expReady;
        logic       expWr;
        logic       expIdle;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        held.delete();
        lastG    = 1;
        streak   = 0;
        accepted = 0;
        pushed   = 0;
    endtask

    // Drive one cycle at the falling edge, compare outputs against the model, then advance the model.
    task automatic step(input logic en, input logic [1:0] v, input logic f,
                        input logic [W-1:0] b0, input logic [W-1:0] b1);
        int  w;
        bit  fire;
        bit  free;
        logic [1:0] eRdy;
        @(negedge clock);
        enable   = en;
        reqValid = v;
        qFull    = f;
        reqBus0  = b0;
        reqBus1  = b1;
        #1;
        fire = (held.size() > 0) && !f;
        free = (held.size() == 0) || fire;
        w = -1;
        if (en && free && v != 2'b00) begin
            if (v == 2'b01)                    w = 0;
            else if (v == 2'b10)               w = 1;
            else if (streak > 0 && streak < MB) w = lastG;
            else                               w = 1 - lastG;
        end
        eRdy = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
        check("reqReady", W'(reqReady), W'(eRdy));
        check("writeRequest", W'(qWrite), W'(fire));
        check("idle", W'(idle), W'(held.size() == 0 && v == 2'b00));
        if (held.size() > 0) check("bus", qBus, held[0]);
        if (fire) begin
            pushed++;
            void'(held.pop_front());
        end
        if (w >= 0) begin
            held.push_back((w == 0) ? b0 : b1);
            accepted++;
            streak = (w == lastG) ? ((streak < MB) ? streak + 1 : MB) : 1;
            lastG  = w;
        end else if (!v[lastG]) begin
            streak = 0;
        end
    endtask

    initial begin
        resetN   = 1'b0;
        enable   = 1'b0;
        reqValid = 2'b00;
        reqBus0  = '0;
        reqBus1  = '0;
        qFull    = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset_ready", W'(reqReady), W'(2'b00));
        check("reset_wr", W'(qWrite), W'(1'b0));
        check("reset_bus", qBus, '0);
        check("reset_idle", W'(idle), W'(1'b1));
        @(negedge clock);
        resetN = 1'b1;

        // Hand-derived vectors: contention burst, held-full, enable low, alternating valids.
        tbl.push_back('{1'b1, 2'b11, 1'b0, 2'b01, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0});
        for (int i = 0; i < 4; i++) tbl.push_back('{1'b1, 2'b11, 1'b0, 2'b10, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0});
        for (int i = 0; i < 5; i++) tbl.push_back('{1'b1, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2'b11, 1'b0, 2'b01, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2'b10, 1'b0, 2'b10, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 2'b01, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 2'b10, 1'b0, 2'b10, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1});

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].v, tbl[i].full, W'(32'h100000 + i), W'(32'h080000 + i));
            check($sformatf("tbl%0d_ready", i), W'(reqReady), W'(tbl[i].expReady));
            check($sformatf("tbl%0d_wr", i), W'(qWrite), W'(tbl[i].expWr));
            check($sformatf("tbl%0d_idle", i), W'(idle), W'(tbl[i].expIdle));
        end

        // Single request: accepted at once, pushed next cycle, exactly one strobe.
        step(1'b1, 2'b01, 1'b0, 25'h1_2345_A, '0);
        check("single_ready", W'(reqReady), W'(2'b01));
        step(1'b1, 2'b00, 1'b0, '0, '0);
        check("single_wr", W'(qWrite), W'(1'b1));
        check("single_bus", qBus, 25'h1_2345_A);
        step(1'b1, 2'b00, 1'b0, '0, '0);
        check("single_one_strobe", W'(qWrite), W'(1'b0));

        // Reset while an entry is about to push: held word discarded, no strobe.
        step(1'b1, 2'b01, 1'b0, 25'h0_BEEF_1, '0);
        @(negedge clock);
        resetN   = 1'b0;
        reqValid = 2'b01;
        #1;
        check("rst_mid_wr", W'(qWrite), W'(1'b0));
        check("rst_mid_ready", W'(reqReady), W'(2'b00));
        check("rst_mid_idle_busy", W'(idle), W'(1'b0));
        @(negedge clock);
        reqValid = 2'b00;
        #1;
        check("rst_mid_idle_free", W'(idle), W'(1'b1));
        model_reset();
        @(negedge clock);
        resetN = 1'b1;
        step(1'b1, 2'b00, 1'b0, '0, '0);
        check("rst_no_push", W'(qWrite), W'(1'b0));

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 9) != 0), 2'($urandom), ($urandom_range(0, 3) == 0),
                 W'($urandom), W'($urandom));
        end
        for (int n = 0; n < 4; n++) step(1'b1, 2'b00, 1'b0, '0, '0);
        check("words_conserved", W'(accepted), W'(pushed + held.size()));
        check("drained_idle", W'(idle), W'(1'b1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
